mul: RTL and testbench
======================

MUL -- requirements
Module: mul

Interface
REQ-001 The block SHALL have an input `clk`, 1 bit, which is the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have an input `reset`, 1 bit, which is an asynchronous, active-high reset.
REQ-003 The block SHALL have an input `a_operand`, 32 bits, which is an IEEE-754 single-precision operand A.
REQ-004 The block SHALL have an input `b_operand`, 32 bits, which is an IEEE-754 single-precision operand B.
REQ-005 The block SHALL have an output `result`, 32 bits, which is the registered product A×B.
REQ-006 The block SHALL have an output `Exception`, 1 bit, which is set when either operand has exponent 8'hFF (Inf or NaN).
REQ-007 The block SHALL have an output `Overflow`, 1 bit, which is set when the biased result exponent is ≥255.
REQ-008 The block SHALL have an output `Underflow`, 1 bit, which is set when the biased result exponent is ≤0.

Function
REQ-009 The block SHALL have a latency of 1 cycle: operands sampled at rising edge N SHALL produce `result` and the flags valid after edge N; there is no handshake and a new operand pair is accepted every cycle.
REQ-010 The result sign SHALL be a[31] XOR b[31].
REQ-011 The product SHALL be computed as a 24×24 unsigned multiply of {1,a[22:0]} and {1,b[22:0]}, giving a 48-bit value P.
REQ-012 Normalisation: if P[47]=1, the mantissa SHALL be taken from P[46:24] and the exponent incremented by 1; otherwise the mantissa SHALL be taken from P[45:23].
REQ-013 The biased exponent SHALL be computed in signed 10-bit arithmetic as a[30:23] + b[30:23] − 127 + normalisation increment + rounding carry.
REQ-014 Output priority SHALL be, highest first:
- Exception: `result`=32'h0, Overflow=0, Underflow=0.
- Zero operand (exponent 0; denormals are treated as zero): `result`={sign,31'b0}, flags 0.
- Overflow: `result`={sign,8'hFF,23'b0}.
- Underflow: `result`={sign,31'b0}.
- Otherwise: `result`={sign,exp[7:0],mantissa}.
REQ-015 Exactly one of Exception, Overflow and Underflow SHALL be asserted at most in any cycle.
REQ-016 The overflow and underflow tests SHALL use the exponent after rounding.

Reset
REQ-017 While `reset`=1, `result`, `Exception`, `Overflow` and `Underflow` SHALL be 0 immediately, without waiting for a clock edge.
REQ-018 The first valid output SHALL appear after the first rising edge of `clk` following deassertion of `reset`.
REQ-019 A reset asserted mid-stream SHALL discard the pending product.

Configuration
REQ-020 Rounding SHALL be selected by the macro MUL_ROUND_NEAREST_EN.
REQ-021 When MUL_ROUND_NEAREST_EN is defined, the mantissa SHALL be rounded to nearest-even using the guard, round and sticky bits below the selected mantissa field.
REQ-022 When a rounding mantissa carry-out occurs, the mantissa SHALL become 0 and the exponent SHALL be incremented.
REQ-023 When MUL_ROUND_NEAREST_EN is not defined, the mantissa SHALL be truncated.
REQ-024 All Verification vectors below are exact and SHALL give identical results in both configurations.

Verification
REQ-025 A bench SHALL check: a=32'h7F9B851F (NaN), b=32'hC04EB852 → Exception=1, result=32'h00000000, Overflow=0, Underflow=0.
REQ-026 A bench SHALL check: a=32'h40500000 (3.25), b=32'hC0080000 (−2.125) → result=32'hC0DD0000 (−6.90625), all flags 0.
REQ-027 A bench SHALL check: a=32'h40B00000 (5.5), b=32'hC0B00000 (−5.5) → result=32'hC1F20000 (−30.25), all flags 0.
REQ-028 A bench SHALL check: a=32'h20B116B8, b=32'h10181E3A (biased exponent −30) → Underflow=1, result=32'h00000000.
REQ-029 A bench SHALL check: a=32'h420C0000 (35), b=32'h41540000 (13.25) → result=32'h43E7E000 (463.75), all flags 0.
REQ-030 A bench SHALL check: a=32'h7F000000, b=32'h40000000 → Overflow=1, result=32'h7F800000.
REQ-031 A bench SHALL check that asserting `reset` mid-stream clears all outputs to 0 immediately, and that the first product after release appears one edge later.

Source files
------------

// File: rtl/mul.sv
// mul: registered IEEE-754 single-precision multiplier with Inf/NaN, overflow and underflow flags.
// Define MUL_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module mul (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);
    logic              sign, exc, zero, norm, round_up, carry, ovf, unf;
    logic [47:0]       p;
    logic [22:0]       mant_t, mant;
    logic [23:0]       mant_r;
    logic signed [9:0] exp;

    always_comb begin
        sign = a_operand[31] ^ b_operand[31];
        exc = (&a_operand[30:23]) | (&b_operand[30:23]);
        zero = ~|a_operand[30:23] | ~|b_operand[30:23];
        p = 48'({1'b1, a_operand[22:0]}) * 48'({1'b1, b_operand[22:0]});
        norm = p[47];
        mant_t = norm ? p[46:24] : p[45:23];
`ifdef MUL_ROUND_NEAREST_EN
        // guard & (round | sticky | lsb) is round-half-to-even
        round_up = (norm ? p[23] : p[22]) &
                   ((norm ? p[22] : p[21]) | (norm ? |p[21:0] : |p[20:0]) | mant_t[0]);
`else
        round_up = 1'b0;
`endif
        mant_r = {1'b0, mant_t} + {23'b0, round_up};
        carry = mant_r[23];
        mant = carry ? 23'b0 : mant_r[22:0];
        exp = $signed({2'b0, a_operand[30:23]} + {2'b0, b_operand[30:23]} +
                      {9'b0, norm} + {9'b0, carry} - 10'd127);
        ovf = exp >= 10'sd255;
        unf = exp <= 10'sd0;
    end

`ifndef MUL_ROUND_NEAREST_EN
    logic unused_lsbs;
    assign unused_lsbs = ^p[22:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= 32'h0;
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            result    <= exc  ? 32'h0 :
                         zero ? {sign, 31'b0} :
                         ovf  ? {sign, 8'hFF, 23'b0} :
                         unf  ? {sign, 31'b0} : {sign, exp[7:0], mant};
            Exception <= exc;
            Overflow  <= !exc && !zero && ovf;
            Underflow <= !exc && !zero && !ovf && unf;
        end
    end
endmodule

// File: tb/tb_mul.sv
// tb_mul: scoreboard bench for mul; a driver queues expected products, a monitor checks each output cycle.
module tb_mul;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_operand, b_operand, result;
    logic        Exception, Overflow, Underflow;

    typedef struct packed {
        logic [31:0] a, b, r;
        logic        e, o, u;
    } exp_t;

    exp_t q[$];
    exp_t it;
    int   n_chk = 0;
    int   n_fail = 0;

    mul dut (
        .clk(clk), .reset(reset), .a_operand(a_operand), .b_operand(b_operand),
        .result(result), .Exception(Exception), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product, normalised by magnitude, rounded by comparing the remainder to one half
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t m;
        int e, sh;
        logic s;
        longint unsigned prod, mant;
`ifdef MUL_ROUND_NEAREST_EN
        longint unsigned rem, half;
`endif
        m = '0;
        m.a = a;
        m.b = b;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            m.e = 1'b1;
            return m;
        end
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
            m.r = {s, 31'b0};
            return m;
        end
        prod = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        sh = (prod >= (64'd1 << 47)) ? 24 : 23;
        if (sh == 24) e++;
        mant = prod >> sh;
`ifdef MUL_ROUND_NEAREST_EN
        rem = prod - (mant << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant++;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e++;
        end
`endif
        if (e >= 255) begin
            m.r = {s, 8'hFF, 23'b0};
            m.o = 1'b1;
        end else if (e <= 0) begin
            m.r = {s, 31'b0};
            m.u = 1'b1;
        end else begin
            m.r = {s, e[7:0], mant[22:0]};
        end
        return m;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 11);
        if (sel == 0) r[30:23] = 8'h00;
        else if (sel == 1) r[30:23] = 8'hFF;
        else if (sel == 2) r[30:23] = 8'($urandom_range(1, 40));
        else if (sel == 3) r[30:23] = 8'($urandom_range(200, 254));
        else if (sel >= 6) r[30:23] = 8'($urandom_range(100, 154));
        if (sel == 11) r[22:0] = 23'h7FFFFF;
        return r;
    endfunction

    task automatic drive_now(input logic [31:0] a, input logic [31:0] b);
        a_operand = a;
        b_operand = b;
        q.push_back(model(a, b));
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive_now(a, b);
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if ({result, Exception, Overflow, Underflow} !== 35'h0) begin
            n_fail++;
            $display("FAIL %s: got result=%h E=%b O=%b U=%b, want all zero",
                     name, result, Exception, Overflow, Underflow);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check_zero("reset_hold");
            end else if (q.size() > 0) begin
                it = q.pop_front();
                n_chk++;
                if ({result, Exception, Overflow, Underflow} !== {it.r, it.e, it.o, it.u}) begin
                    n_fail++;
                    $display("FAIL product a=%h b=%h: got result=%h E=%b O=%b U=%b, want result=%h E=%b O=%b U=%b",
                             it.a, it.b, result, Exception, Overflow, Underflow, it.r, it.e, it.o, it.u);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        a_operand = 32'h0;
        b_operand = 32'h0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        drive(32'h7F9B851F, 32'hC04EB852);
        drive(32'h40500000, 32'hC0080000);
        drive(32'h40B00000, 32'hC0B00000);
        drive(32'h20B116B8, 32'h10181E3A);
        drive(32'h420C0000, 32'h41540000);
        drive(32'h7F000000, 32'h40000000);
        drive(32'h00000000, 32'hC0B00000);
        drive(32'h80400000, 32'h7F800000);
        drive(32'h3F800000, 32'h3F800000);
        drive(32'h40500000, 32'hC0080000);
        // a pending product is in flight when reset hits between edges
        drive(32'h40B00000, 32'hC0B00000);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_zero("reset_release");
        drive_now(32'h420C0000, 32'h41540000);
        for (int i = 0; i < 600; i++) drive(rnd_op(), rnd_op());
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d products still pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
